// File: rtl/ahb_lite_pkg.sv
// AHB-Lite types and helpers shared by the SRAM slave and the vgm_ahb agent monitor.
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Lane enables of a 32-bit bus for a given transfer size and low address bits.
   function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << addr_lo;
         HSIZE_HALF: be = 4'b0011 << addr_lo;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_lite_sram_mem.sv
// DEPTH x 32 single-clock SRAM: one byte-lane write port, one registered read port.
module ahb_lite_sram_mem #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Read-before-write: a same-edge read returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address decode, wait-state FSM and write-to-read forwarding.
//   state   | meaning
//   IDLE    | no data phase, ready
//   WAIT    | OKAY data phase stretched by the wait counter
//   DONE    | last OKAY data-phase cycle, write commits here
//   ERR1    | first ERROR cycle, not ready
//   ERR2    | second ERROR cycle, ready
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] word_q;
   logic [1:0]    addr_lo_q;
   logic [2:0]    size_q;
   logic          write_q;
   logic [3:0]    wait_cnt_q;
   logic [3:0]    fwd_be_q;
   logic [31:0]   fwd_data_q;
   logic [31:0]   mem_rdata;

   htrans_t       trans;
   logic          slave_ready;
   logic          accept;
   logic          addr_err;
   logic [AW-1:0] haddr_word;
   logic [3:0]    be_q;
   logic          mem_we;
   logic          mem_re;
   logic          fwd_hit;
   logic          rd_phase;
   logic          unused_hburst;

   assign unused_hburst = ^HBURST;

   assign trans       = htrans_t'(HTRANS);
   assign haddr_word  = HADDR[AW+1:2];
   assign slave_ready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
   assign accept      = HSEL && HREADY && slave_ready
                        && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

   assign addr_err = (HADDR >= ADDR_LIMIT)
                     || (HSIZE > 3'd2)
                     || (HSIZE == HSIZE_HALF && HADDR[0])
                     || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);

   assign be_q    = byte_enable(size_q, addr_lo_q);
   assign mem_we  = (state_q == ST_DONE) && write_q;
   assign mem_re  = accept && !addr_err && !HWRITE;
   // A read accepted while a write to the same word commits must see the new lanes.
   assign fwd_hit = mem_we && (word_q == haddr_word);

   always_comb begin
      state_d   = state_q;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state_q)
         ST_IDLE, ST_DONE: state_d = ST_IDLE;
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            if (wait_cnt_q == 4'd1) state_d = ST_DONE;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP   = HRESP_ERROR;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         if (addr_err)              state_d = ST_ERR1;
         else if (WAIT_STATES == 0) state_d = ST_DONE;
         else                       state_d = ST_WAIT;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         addr_lo_q  <= 2'b00;
         size_q     <= 3'd0;
         write_q    <= 1'b0;
         wait_cnt_q <= 4'd0;
         fwd_be_q   <= 4'b0000;
         fwd_data_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            word_q     <= haddr_word;
            addr_lo_q  <= HADDR[1:0];
            size_q     <= HSIZE;
            write_q    <= HWRITE;
            wait_cnt_q <= 4'(WAIT_STATES);
            fwd_be_q   <= fwd_hit ? be_q : 4'b0000;
            fwd_data_q <= HWDATA;
         end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
         end
      end
   end

   assign rd_phase = ((state_q == ST_WAIT) || (state_q == ST_DONE)) && !write_q;

   always_comb begin
      HRDATA = 32'd0;
      if (rd_phase) begin
         for (int i = 0; i < 4; i++) begin
            HRDATA[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8] : mem_rdata[8*i +: 8];
         end
      end
   end

   ahb_lite_sram_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (HCLK),
      .we    (mem_we),
      .be    (be_q),
      .waddr (word_q),
      .wdata (HWDATA),
      .re    (mem_re),
      .raddr (haddr_word),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two slaves (0 and 3 wait states) on one pipelined bus.
module tb_ahb_lite_sram_slave;

   localparam int DEPTH = 1024;
   localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NS = 2'd2, SQ = 2'd3;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        hsel0 = 1'b0, hsel3 = 1'b0;
   logic [31:0] haddr = 32'd0;
   logic [1:0]  htrans = IDL;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd0;
   logic [2:0]  hburst = 3'd0;
   logic [31:0] hwdata = 32'd0;
   logic        hready;
   logic        ro0, resp0, ro3, resp3;
   logic [31:0] rdata0, rdata3;

   always #5 hclk = ~hclk;

   // Only the slave owning the data phase can pull ready low; the other idles high.
   assign hready = ro0 & ro3;

   ahb_lite_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
      .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rdata0));

   ahb_lite_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
      .HCLK(hclk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rdata3));

   typedef struct {
      bit          tgt;
      logic [1:0]  trans;
      bit          write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          err;
      logic [31:0] rdata;
      bit          auto_exp;
   } vec_t;

   logic [31:0] ref_mem [2][DEPTH];
   int n_tests = 0;
   int n_fail  = 0;
   bit abort   = 1'b0;

   function automatic vec_t mk(input bit tgt, input logic [1:0] trans, input bit write,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit err,
                               input logic [31:0] rdata, input bit auto_exp = 1'b0);
      vec_t v;
      v.tgt = tgt; v.trans = trans; v.write = write; v.size = size; v.addr = addr;
      v.wdata = wdata; v.err = err; v.rdata = rdata; v.auto_exp = auto_exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Transfer-level model: an access is legal when in range, at most a word, and
   // naturally aligned; legal writes update exactly 2**size bytes starting at addr.
   function automatic bit model_err(input vec_t v);
      if (v.addr >= 32'(DEPTH * 4)) return 1'b1;
      if (v.size > 3'd2) return 1'b1;
      return (v.addr % (32'd1 << v.size)) != 32'd0;
   endfunction

   task automatic model_apply(inout vec_t v);
      bit err;
      int w;
      int lane;
      err = model_err(v);
      w   = int'(v.addr >> 2);
      if (v.auto_exp) begin
         v.err   = err;
         v.rdata = (err || v.write) ? 32'd0 : ref_mem[v.tgt][w];
      end
      if (!err && v.write) begin
         for (int b = 0; b < (1 << v.size); b++) begin
            lane = int'(v.addr[1:0]) + b;
            ref_mem[v.tgt][w][8*lane +: 8] = v.wdata[8*lane +: 8];
         end
      end
   endtask

   task automatic drive_addr(input vec_t v);
      logic sel;
      sel    = v.trans[1] ? 1'b1 : 1'($urandom_range(0, 1));
      hsel0  = (v.tgt == 1'b0) ? sel : 1'b0;
      hsel3  = (v.tgt == 1'b1) ? sel : 1'b0;
      htrans = v.trans;
      haddr  = v.addr;
      hwrite = v.write;
      hsize  = v.size;
      hburst = 3'($urandom_range(0, 7));
   endtask

   task automatic drive_idle();
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = IDL;
      haddr  = $urandom();
      hwrite = 1'b0;
      hsize  = 3'd0;
   endtask

   task automatic check_dp(input string name, input vec_t dp, input int k);
      logic        ro, rs, exp_ro;
      logic [31:0] rd;
      int          ws;
      ro = dp.tgt ? ro3 : ro0;
      rs = dp.tgt ? resp3 : resp0;
      rd = dp.tgt ? rdata3 : rdata0;
      ws = dp.tgt ? 3 : 0;
      if (dp.err) begin
         exp_ro = (k > 0);
         check($sformatf("%s err ready/resp c%0d", name, k), {30'd0, ro, rs}, {30'd0, exp_ro, 1'b1});
         check($sformatf("%s err rdata c%0d", name, k), rd, 32'd0);
      end else begin
         exp_ro = (k >= ws);
         check($sformatf("%s ready/resp c%0d", name, k), {30'd0, ro, rs}, {30'd0, exp_ro, 1'b0});
         if (exp_ro && !dp.write) check($sformatf("%s rdata", name), rd, dp.rdata);
      end
   endtask

   // Runs a list of address phases back-to-back; each data phase overlaps the next address phase.
   task automatic run_vecs(input string tag, input vec_t q[$]);
      vec_t dp, v;
      bit   dp_valid;
      int   k;
      dp_valid = 1'b0;
      dp = mk(0, IDL, 0, 0, 0, 0, 0, 0);
      v  = dp;
      for (int i = 0; i <= q.size() && !abort; i++) begin
         if (i < q.size()) begin
            v = q[i];
            if (v.trans[1]) model_apply(v);
            drive_addr(v);
         end else begin
            v = mk(0, IDL, 0, 0, 0, 0, 0, 0);
            drive_idle();
         end
         hwdata = (dp_valid && dp.write) ? dp.wdata : $urandom();
         k = 0;
         forever begin
            @(negedge hclk);
            if (dp_valid) check_dp($sformatf("%s#%0d", tag, i - 1), dp, k);
            else check($sformatf("%s#%0d quiet", tag, i - 1), {28'd0, ro0, resp0, ro3, resp3}, 32'b1010);
            if (hready) break;
            k++;
            if (k > 20) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s#%0d timeout: still stretched after %0d cycles, want done", tag, i - 1, k);
               abort = 1'b1;
               break;
            end
         end
         @(posedge hclk);
         #1;
         dp_valid = v.trans[1];
         dp = v;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      vec_t rnd[$];
      vec_t rv;
      logic [31:0] a;

      // Reset state
      drive_idle();
      repeat (2) @(negedge hclk);
      check("reset ws0 ready/resp", {30'd0, ro0, resp0}, 32'b10);
      check("reset ws3 ready/resp", {30'd0, ro3, resp3}, 32'b10);
      check("reset ws0 rdata", rdata0, 32'd0);
      check("reset ws3 rdata", rdata3, 32'd0);
      hreset = 1'b0;
      @(posedge hclk);
      #1;

      //               tgt trans wr size addr          wdata          err  exp_rdata
      tbl.push_back(mk(0, NS,  1, 2, 32'h10,   32'hDEADBEEF, 0, 32'h0));
      tbl.push_back(mk(0, NS,  0, 2, 32'h10,   32'h0,        0, 32'hDEADBEEF));
      tbl.push_back(mk(0, NS,  1, 2, 32'h20,   32'h0,        0, 32'h0));
      tbl.push_back(mk(0, SQ,  1, 0, 32'h21,   32'h0000AA00, 0, 32'h0));
      tbl.push_back(mk(0, SQ,  1, 1, 32'h22,   32'h55550000, 0, 32'h0));
      tbl.push_back(mk(0, IDL, 0, 0, 32'h20,   32'h0,        0, 32'h0));
      tbl.push_back(mk(0, NS,  0, 2, 32'h20,   32'h0,        0, 32'h5555AA00));
      tbl.push_back(mk(0, NS,  1, 2, 32'h40,   32'h12345678, 0, 32'h0));
      tbl.push_back(mk(0, SQ,  0, 2, 32'h40,   32'h0,        0, 32'h12345678));
      tbl.push_back(mk(0, NS,  1, 2, 32'h44,   32'hAABBCCDD, 0, 32'h0));
      tbl.push_back(mk(0, BSY, 0, 0, 32'h44,   32'h0,        0, 32'h0));
      tbl.push_back(mk(0, NS,  1, 0, 32'h44,   32'h000000EE, 0, 32'h0));
      tbl.push_back(mk(0, NS,  0, 2, 32'h44,   32'h0,        0, 32'hAABBCCEE));
      tbl.push_back(mk(0, NS,  1, 2, 32'h0,    32'hCAFEF00D, 0, 32'h0));
      tbl.push_back(mk(0, NS,  1, 2, 32'h1000, 32'h77777777, 1, 32'h0));
      tbl.push_back(mk(0, NS,  0, 2, 32'h0,    32'h0,        0, 32'hCAFEF00D));
      tbl.push_back(mk(0, NS,  0, 1, 32'h3,    32'h0,        1, 32'h0));
      tbl.push_back(mk(0, NS,  0, 3, 32'h8,    32'h0,        1, 32'h0));
      tbl.push_back(mk(0, NS,  1, 2, 32'h6,    32'h33333333, 1, 32'h0));
      tbl.push_back(mk(0, NS,  1, 1, 32'h2,    32'hFFFF0000, 0, 32'h0));
      tbl.push_back(mk(0, NS,  0, 2, 32'h0,    32'h0,        0, 32'hFFFFF00D));
      tbl.push_back(mk(0, NS,  1, 2, 32'hFFC,  32'h0BADF00D, 0, 32'h0));
      tbl.push_back(mk(0, NS,  0, 2, 32'hFFC,  32'h0,        0, 32'h0BADF00D));
      tbl.push_back(mk(0, NS,  0, 2, 32'h1000, 32'h0,        1, 32'h0));
      tbl.push_back(mk(1, NS,  1, 2, 32'h80,   32'h11111111, 0, 32'h0));
      tbl.push_back(mk(1, NS,  0, 2, 32'h80,   32'h0,        0, 32'h11111111));
      tbl.push_back(mk(1, NS,  0, 2, 32'h80,   32'h0,        0, 32'h11111111));
      tbl.push_back(mk(1, NS,  1, 0, 32'h83,   32'h99000000, 0, 32'h0));
      tbl.push_back(mk(1, NS,  0, 2, 32'h80,   32'h0,        0, 32'h99111111));
      tbl.push_back(mk(1, NS,  1, 2, 32'h1000, 32'h44444444, 1, 32'h0));
      tbl.push_back(mk(0, NS,  0, 2, 32'h10,   32'h0,        0, 32'hDEADBEEF));
      tbl.push_back(mk(1, NS,  0, 2, 32'h80,   32'h0,        0, 32'h99111111));
      run_vecs("dir", tbl);

      // Reset during a WAIT cycle of a write: outputs drop at once and the write is lost.
      rv = mk(1, NS, 1, 2, 32'h80, 32'h22222222, 0, 32'h0);
      drive_addr(rv);
      @(posedge hclk);
      #1;
      drive_idle();
      hwdata = rv.wdata;
      @(negedge hclk);
      check("rst_mid in wait", {31'd0, ro3}, 32'd0);
      #2 hreset = 1'b1;
      #1;
      check("rst_mid ready/resp", {30'd0, ro3, resp3}, 32'b10);
      check("rst_mid rdata", rdata3, 32'd0);
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hreset = 1'b0;
      @(posedge hclk);
      #1;
      tbl.delete();
      tbl.push_back(mk(1, NS, 0, 2, 32'h80, 32'h0, 0, 32'h99111111));
      run_vecs("rst", tbl);

      // Randomized traffic against the transfer-level model.
      for (int t = 0; t < 2; t++) begin
         for (int w = 0; w < 32; w++) rnd.push_back(mk(t[0], NS, 1, 2, 32'(w * 4), $urandom(), 0, 0, 1));
      end
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 19) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
         else a = 32'($urandom_range(0, 127));
         rnd.push_back(mk(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
                          a, $urandom(), 0, 0, 1));
      end
      run_vecs("rnd", rnd);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

- AHB-Lite slave exposing a word-addressed, byte-lane-writable SRAM with a programmable number of wait states and a two-cycle ERROR response.
- It is the RTL target driven by the vgm_ahb agent (driver in front, monitor observing) and is the first DUT on which that agent is exercised.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; valid byte addresses 0 .. DEPTH*4-1
- WAIT_STATES, 0, extra data-phase cycles inserted on every OKAY transfer (0..15)

Ports:
- HCLK  in  1  the single clock; all logic is rising-edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
- HBURST  in  3  accepted and ignored; each beat is decoded independently
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready (previous data phase completing)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data, valid when HREADYOUT=1 and HRESP=0 in a read data phase

## Operation
- **Accept.** An address phase is accepted on a rising edge with HSEL=1, HTRANS[1]=1 and HREADY=1. On that edge, HADDR[31:0], HWRITE and HSIZE are latched.
- **Not accepted.** IDLE, BUSY or HSEL=0 start no transfer. The slave goes to, or stays in, IDLE with HREADYOUT=1 and HRESP=0.
- **Error check.** Decoded from the address phase. ERROR if any of:
  - HADDR >= DEPTH*4
  - HSIZE > 2
  - HADDR is misaligned for HSIZE (halfword: HADDR[0]≠0; word: HADDR[1:0]≠0)
- **FSM states:**
  - IDLE: HREADYOUT=1, HRESP=0
  - WAIT: HREADYOUT=0, HRESP=0; down-counter loaded with WAIT_STATES
  - DONE: HREADYOUT=1, HRESP=0
  - ERR1: HREADYOUT=0, HRESP=1
  - ERR2: HREADYOUT=1, HRESP=1
- **Transitions on accept:**
  - erroneous → ERR1
  - else WAIT_STATES=0 → DONE
  - else → WAIT
- **Other transitions:**
  - WAIT → DONE when the counter reaches 1
  - ERR1 → ERR2 unconditionally
  - DONE/ERR2 → IDLE if no new accept, else per the accept rules (back-to-back pipelined transfers)
- **Byte lanes.** Enables derive from latched HADDR[1:0]/HSIZE:
  - byte: 1 << addr[1:0]
  - halfword: 4'b0011 << addr[1:0]
  - word: 4'b1111
- **Writes.** Committed to the word at latched HADDR[..:2] on the last data-phase edge (the DONE cycle), using HWDATA lanes selected by the enables. An ERROR transfer never writes.
- **Reads.**
  - HRDATA returns the full 32-bit word; the master picks lanes.
  - HRDATA is registered and loaded on the accept edge, so it is valid in DONE and held through WAIT.
  - HRDATA=0 in ERR1/ERR2.
- **Read-after-write hazard.** When a read is accepted on the same edge a write commits to the same word, the returned word is the old word with the written lanes replaced by the new bytes.

## Timing
- **Reset (async assert, sync deassert by system):**
  - HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE
  - memory contents not reset
- **Latency:**
  - OKAY transfer: data phase lasts 1+WAIT_STATES cycles
  - ERROR transfer: exactly 2 cycles, no wait states
- **Address phase during stretched data phase.** An address phase presented while HREADYOUT=0 is not accepted, since HREADY=0.
- **Reset mid-transfer.** Aborts it, and any pending write is dropped.
- **HSEL=0 with HREADY=0** (another slave stretching) is ignored.

## Structure
- **Shared package ahb_lite_pkg** holds:
  - htrans_t
  - hsize_t
  - HRESP_OKAY/HRESP_ERROR constants
  - the byte-enable function, so the vgm_ahb monitor reuses it
- **FSM state enum** is local to the slave.
- **Sub-module ahb_lite_sram_mem:**
  - DEPTH×32 array
  - one write port with 4-bit byte enable
  - one synchronous read port
  - no reset
- **Slave top** contains the decode, FSM, wait counter and forwarding mux.

## Test plan
- **Word write/read, WAIT_STATES=0:** write 0xDEADBEEF @0x10, then read @0x10 → HRDATA=0xDEADBEEF in the first data-phase cycle, HRESP=0 throughout.
- **Sub-word writes:**
  - preload 0x00000000
  - byte write 0xAA @0x21, then halfword 0x5555 @0x22
  - read @0x20 → 0x5555AA00
- **Back-to-back hazard:** write 0x12345678 @0x40 immediately followed by pipelined read @0x40 → read returns 0x12345678.
- **WAIT_STATES=3:** read → HREADYOUT low exactly 3 cycles, then high with correct data; next NONSEQ held in address phase is accepted only on the HREADY=1 edge.
- **Errors:**
  - write @DEPTH*4 → HREADYOUT 0 then 1 with HRESP=1 both cycles; memory unchanged
  - halfword @0x3 → ERROR
  - HSIZE=3 → ERROR
- **Reset mid-transfer:** assert HRESET during a WAIT cycle of a write → outputs go to reset values immediately; the target word keeps its old value.
